// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : shared register-file constants and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;

    function automatic logic is_arch_reg(input logic [IDX_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_tag_table.sv
// ============================================================================
// reg_file_tag_table : per-register pending ROB tag, renamed on the falling
// edge, cleared by a matching commit on the rising edge. Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_tag_table
    import reg_file_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ren_en_i,
    input  logic [IDX_W-1:0] ren_idx_i,
    input  logic [TAG_W-1:0] ren_tag_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic [TAG_W-1:0] clr_tag_i,
    output logic             clr_hit_o,
    input  logic [IDX_W-1:0] rd0_idx_i,
    input  logic [IDX_W-1:0] rd1_idx_i,
    input  logic [IDX_W-1:0] rd2_idx_i,
    output logic [TAG_W-1:0] rd0_tag_o,
    output logic [TAG_W-1:0] rd1_tag_o,
    output logic [TAG_W-1:0] rd2_tag_o
);

    logic [TAG_W-1:0] tag_eff [NUM_REGS];

    assign tag_eff[0] = '0;

    // Each flag lives in one clock domain: the tag is pending while the
    // falling-edge flag differs from the rising-edge flag, so a rename sets
    // them unequal and a commit clear sets them equal.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_tag
        logic [TAG_W-1:0] tag_q, tag_d;
        logic             ren_q, ren_d;
        logic             clr_q, clr_d;

        always_comb begin
            tag_d = tag_q;
            ren_d = ren_q;
            if (ren_en_i && (ren_idx_i == IDX_W'(r))) begin
                tag_d = ren_tag_i;
                ren_d = ~clr_q;
            end
        end

        always_comb begin
            clr_d = clr_q;
            if (clr_hit_o && (clr_idx_i == IDX_W'(r)))
                clr_d = ren_q;
        end

        always_ff @(negedge clk or negedge rst) begin
            if (!rst) begin
                tag_q <= '0;
                ren_q <= 1'b0;
            end else begin
                tag_q <= tag_d;
                ren_q <= ren_d;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) clr_q <= 1'b0;
            else      clr_q <= clr_d;
        end

        assign tag_eff[r] = (ren_q ^ clr_q) ? tag_q : '0;
    end

    assign clr_hit_o = clr_en_i && is_arch_reg(clr_idx_i)
                       && (tag_eff[clr_idx_i] == clr_tag_i);

    assign rd0_tag_o = tag_eff[rd0_idx_i];
    assign rd1_tag_o = tag_eff[rd1_idx_i];
    assign rd2_tag_o = tag_eff[rd2_idx_i];

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : 32x32 architectural register file with ROB tag tracking
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_Entry_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              WP1_Wen,
    input  logic [ROB_Entry_WIDTH-1:0]        WP1_ROBEN,
    input  logic [4:0]                        WP1_DRindex,
    input  logic [31:0]                       WP1_Data,
    input  logic                              WP1_Wen_IQ,
    input  logic [ROB_Entry_WIDTH-1:0]        WP1_ROBEN_IQ,
    input  logic [4:0]                        WP1_DRindex_IQ,
    input  logic [4:0]                        RP1_index1,
    input  logic [4:0]                        RP1_index2,
    output logic [31:0]                       RP1_Reg1,
    output logic [31:0]                       RP1_Reg2,
    output logic [(1<<ROB_Entry_WIDTH)-1:0]   RP1_Reg1_ROBEN,
    output logic [(1<<ROB_Entry_WIDTH)-1:0]   RP1_Reg2_ROBEN,
    input  logic [4:0]                        input_WP1_DRindex_test,
    output logic [(1<<ROB_Entry_WIDTH)-1:0]   output_ROBEN_test
);

    localparam int TAG_OUT_W = 1 << ROB_Entry_WIDTH;

    logic                       wr_hit;
    logic [ROB_Entry_WIDTH-1:0] rd1_tag, rd2_tag, test_tag;
    logic [DATA_W-1:0]          data_rd [NUM_REGS];

    reg_file_tag_table #(
        .TAG_W (ROB_Entry_WIDTH)
    ) u_tag_table (
        .clk       (clk),
        .rst       (rst),
        .ren_en_i  (WP1_Wen_IQ),
        .ren_idx_i (WP1_DRindex_IQ),
        .ren_tag_i (WP1_ROBEN_IQ),
        .clr_en_i  (WP1_Wen),
        .clr_idx_i (WP1_DRindex),
        .clr_tag_i (WP1_ROBEN),
        .clr_hit_o (wr_hit),
        .rd0_idx_i (RP1_index1),
        .rd1_idx_i (RP1_index2),
        .rd2_idx_i (input_WP1_DRindex_test),
        .rd0_tag_o (rd1_tag),
        .rd1_tag_o (rd2_tag),
        .rd2_tag_o (test_tag)
    );

    assign data_rd[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_data
        logic [DATA_W-1:0] data_q, data_d;

        always_comb begin
            data_d = data_q;
            if (wr_hit && (WP1_DRindex == IDX_W'(r)))
                data_d = WP1_Data;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) data_q <= '0;
            else      data_q <= data_d;
        end

        assign data_rd[r] = data_q;
    end

    assign RP1_Reg1          = data_rd[RP1_index1];
    assign RP1_Reg2          = data_rd[RP1_index2];
    assign RP1_Reg1_ROBEN    = TAG_OUT_W'(rd1_tag);
    assign RP1_Reg2_ROBEN    = TAG_OUT_W'(rd2_tag);
    assign output_ROBEN_test = TAG_OUT_W'(test_tag);

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : directed and random checks of reg_file against an array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        WP1_Wen;
    logic [4:0]  WP1_ROBEN;
    logic [4:0]  WP1_DRindex;
    logic [31:0] WP1_Data;
    logic        WP1_Wen_IQ;
    logic [4:0]  WP1_ROBEN_IQ;
    logic [4:0]  WP1_DRindex_IQ;
    logic [4:0]  RP1_index1;
    logic [4:0]  RP1_index2;
    logic [31:0] RP1_Reg1;
    logic [31:0] RP1_Reg2;
    logic [31:0] RP1_Reg1_ROBEN;
    logic [31:0] RP1_Reg2_ROBEN;
    logic [4:0]  input_WP1_DRindex_test;
    logic [31:0] output_ROBEN_test;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdata [32];
    logic [4:0]  mtag  [32];

    always #5 clk = ~clk;

    reg_file #(.ROB_Entry_WIDTH(5)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .WP1_Wen                (WP1_Wen),
        .WP1_ROBEN              (WP1_ROBEN),
        .WP1_DRindex            (WP1_DRindex),
        .WP1_Data               (WP1_Data),
        .WP1_Wen_IQ             (WP1_Wen_IQ),
        .WP1_ROBEN_IQ           (WP1_ROBEN_IQ),
        .WP1_DRindex_IQ         (WP1_DRindex_IQ),
        .RP1_index1             (RP1_index1),
        .RP1_index2             (RP1_index2),
        .RP1_Reg1               (RP1_Reg1),
        .RP1_Reg2               (RP1_Reg2),
        .RP1_Reg1_ROBEN         (RP1_Reg1_ROBEN),
        .RP1_Reg2_ROBEN         (RP1_Reg2_ROBEN),
        .input_WP1_DRindex_test (input_WP1_DRindex_test),
        .output_ROBEN_test      (output_ROBEN_test)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mdata[i] = '0;
            mtag[i]  = '0;
        end
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] t);
        RP1_index1             = a;
        RP1_index2             = b;
        input_WP1_DRindex_test = t;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_reg1"}, RP1_Reg1, mdata[RP1_index1]);
        chk({tag, "_reg2"}, RP1_Reg2, mdata[RP1_index2]);
        chk({tag, "_tag1"}, RP1_Reg1_ROBEN, {27'b0, mtag[RP1_index1]});
        chk({tag, "_tag2"}, RP1_Reg2_ROBEN, {27'b0, mtag[RP1_index2]});
        chk({tag, "_tagt"}, output_ROBEN_test, {27'b0, mtag[input_WP1_DRindex_test]});
    endtask

    // One cycle: inputs applied before the rising edge (commit), then the
    // falling edge (rename); returns 1 ns after the falling edge.
    task automatic step(input logic cw, input logic [4:0] ci, input logic [4:0] ct,
                        input logic [31:0] cd, input logic rw, input logic [4:0] ri,
                        input logic [4:0] rt);
        WP1_Wen        = cw;
        WP1_DRindex    = ci;
        WP1_ROBEN      = ct;
        WP1_Data       = cd;
        WP1_Wen_IQ     = rw;
        WP1_DRindex_IQ = ri;
        WP1_ROBEN_IQ   = rt;
        @(posedge clk);
        if (cw && ci != 5'd0 && mtag[ci] == ct) begin
            mdata[ci] = cd;
            mtag[ci]  = 5'd0;
        end
        @(negedge clk);
        if (rw && ri != 5'd0)
            mtag[ri] = rt;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        model_clear();
        WP1_Wen = 0; WP1_ROBEN = 0; WP1_DRindex = 0; WP1_Data = 0;
        WP1_Wen_IQ = 0; WP1_ROBEN_IQ = 0; WP1_DRindex_IQ = 0;
        set_rd(5'd1, 5'd2, 5'd3);
        #2;
        chk("in_reset_reg1", RP1_Reg1, 32'd0);
        #10 rst = 1'b1;
        @(negedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            set_rd(5'(i), 5'(i), 5'(i));
            #1;
            chk($sformatf("reset_reg_%0d", i), RP1_Reg1, 32'd0);
            chk($sformatf("reset_tag_%0d", i), output_ROBEN_test, 32'd0);
        end
        @(negedge clk);
        #1;

        // rename and commit of r1 in the same cycle, held two cycles
        set_rd(5'd1, 5'd0, 5'd1);
        step(1, 5'd1, 5'd2, 32'd123, 1, 5'd1, 5'd2);
        chk("r1_c1_data", RP1_Reg1, 32'd0);
        chk("r1_c1_tag", output_ROBEN_test, 32'd2);
        check_all("r1_c1");
        step(1, 5'd1, 5'd2, 32'd123, 1, 5'd1, 5'd2);
        chk("r1_c2_data", RP1_Reg1, 32'd123);
        check_all("r1_c2");

        // mismatching commit is dropped
        set_rd(5'd5, 5'd1, 5'd5);
        step(0, 5'd0, 5'd0, 32'd0, 1, 5'd5, 5'd3);
        step(1, 5'd5, 5'd4, 32'd77, 0, 5'd0, 5'd0);
        chk("r5_data", RP1_Reg1, 32'd0);
        chk("r5_tag", output_ROBEN_test, 32'd3);

        // r0 is hard-wired
        set_rd(5'd0, 5'd5, 5'd0);
        step(1, 5'd0, 5'd0, 32'd55, 1, 5'd0, 5'd6);
        step(1, 5'd0, 5'd6, 32'd55, 0, 5'd0, 5'd0);
        chk("r0_data", RP1_Reg1, 32'd0);
        chk("r0_tag", output_ROBEN_test, 32'd0);

        // newer rename overrides older one
        set_rd(5'd2, 5'd5, 5'd2);
        step(0, 5'd0, 5'd0, 32'd0, 1, 5'd2, 5'd7);
        step(0, 5'd0, 5'd0, 32'd0, 1, 5'd2, 5'd9);
        step(1, 5'd2, 5'd7, 32'd44, 0, 5'd0, 5'd0);
        chk("r2_old_data", RP1_Reg1, 32'd0);
        chk("r2_old_tag", output_ROBEN_test, 32'd9);
        step(1, 5'd2, 5'd9, 32'd10, 0, 5'd0, 5'd0);
        chk("r2_new_data", RP1_Reg1, 32'd10);
        chk("r2_new_tag", output_ROBEN_test, 32'd0);

        // clear then rename of the same register within one cycle
        set_rd(5'd4, 5'd2, 5'd4);
        step(0, 5'd0, 5'd0, 32'd0, 1, 5'd4, 5'd3);
        step(1, 5'd4, 5'd3, 32'd5, 1, 5'd4, 5'd8);
        chk("r4_data", RP1_Reg1, 32'd5);
        chk("r4_tag", output_ROBEN_test, 32'd8);
        check_all("r4");

        for (int n = 0; n < 150; n++) begin
            logic [4:0] ci, ri, ct;
            ci = 5'($urandom_range(0, 7));
            ri = 5'($urandom_range(0, 7));
            ct = ($urandom_range(0, 2) != 0) ? mtag[ci] : 5'($urandom);
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step(1'($urandom), ci, ct, $urandom, 1'($urandom), ri, 5'($urandom));
            check_all($sformatf("rnd%0d", n));
        end

        // asynchronous reset in the middle of a cycle
        set_rd(5'd3, 5'd1, 5'd3);
        step(0, 5'd0, 5'd0, 32'd0, 1, 5'd3, 5'd5);
        step(1, 5'd3, 5'd5, 32'd99, 1, 5'd6, 5'd12);
        chk("r3_written", RP1_Reg1, 32'd99);
        WP1_Wen_IQ = 1; WP1_DRindex_IQ = 5'd3; WP1_ROBEN_IQ = 5'd1;
        WP1_Wen = 1; WP1_DRindex = 5'd3; WP1_ROBEN = 5'd0; WP1_Data = 32'hDEAD;
        @(posedge clk);
        #2 rst = 1'b0;
        model_clear();
        #1;
        chk("rst_r3_data", RP1_Reg1, 32'd0);
        for (int i = 0; i < 32; i++) begin
            input_WP1_DRindex_test = 5'(i);
            #1;
            chk($sformatf("rst_tag_%0d", i), output_ROBEN_test, 32'd0);
        end
        WP1_Wen = 0; WP1_Wen_IQ = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        set_rd(5'd3, 5'd6, 5'd6);
        #1;
        check_all("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
